// File: rtl/muller_c_hs_sequencer_if.sv
// Handshake, configuration and status bundle between the pad-side controller
// and the Muller C-element sequencer.
interface muller_c_hs_sequencer_if #(
   parameter int CNT_W  = 8,
   parameter int SKEW_W = 4
);
   logic              start;
   logic              stop;
   logic [CNT_W-1:0]  cfg_count;
   logic [SKEW_W-1:0] cfg_skew;
   logic              cfg_b_first;
   logic              c_in;
   logic              a_out;
   logic              b_out;
   logic              busy;
   logic              done;
   logic              err_early;
   logic              err_timeout;
   logic [CNT_W-1:0]  hs_count;

   modport master (
      output start, stop, cfg_count, cfg_skew, cfg_b_first, c_in,
      input  a_out, b_out, busy, done, err_early, err_timeout, hs_count
   );

   modport slave (
      input  start, stop, cfg_count, cfg_skew, cfg_b_first, c_in,
      output a_out, b_out, busy, done, err_early, err_timeout, hs_count
   );
endinterface

// File: rtl/muller_c_hs_sequencer.sv
// Drives a C-element through repeated four-phase handshakes, checks that its
// output only moves after both inputs agree, and counts completed handshakes.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  S_IDLE   | waiting for an accepted start
//  S_R_LEAD | leading input goes high, skew timer loaded
//  S_R_SKEW | only leading input high; c must stay 0
//  S_R_WAIT | both inputs high; waiting for c to rise
//  S_F_LEAD | leading input goes low, skew timer loaded
//  S_F_SKEW | only trailing input high; c must stay 1
//  S_F_WAIT | both inputs low; waiting for c to fall
//  S_DONE   | one-cycle done pulse
//  S_ERROR  | early or timeout fault latched, inputs held low
module muller_c_hs_sequencer #(
   parameter int CNT_W   = 8,
   parameter int SKEW_W  = 4,
   parameter int TIMEOUT = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   muller_c_hs_sequencer_if.slave hs
);
   localparam int TO_W = $clog2(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_R_LEAD, S_R_SKEW, S_R_WAIT,
      S_F_LEAD, S_F_SKEW, S_F_WAIT, S_DONE, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic              c_s1, c_s2;
   logic [CNT_W-1:0]  cnt_q;
   logic [SKEW_W-1:0] skew_q;
   logic              b_first_q;
   logic [SKEW_W-1:0] skew_cnt_q, skew_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              lead_q, lead_d, trail_q, trail_d;
   logic [CNT_W-1:0]  hs_q, hs_d, hs_inc;
   logic              early_q, early_d, tout_q, tout_d;
   logic              cfg_load, idle_like, accept;

   assign hs_inc    = hs_q + CNT_W'(1);
   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
   assign accept    = hs.start && (hs.cfg_count != '0) && idle_like;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         c_s1       <= 1'b0;
         c_s2       <= 1'b0;
         cnt_q      <= '0;
         skew_q     <= '0;
         b_first_q  <= 1'b0;
         skew_cnt_q <= '0;
         to_cnt_q   <= '0;
         lead_q     <= 1'b0;
         trail_q    <= 1'b0;
         hs_q       <= '0;
         early_q    <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         c_s1       <= hs.c_in;
         c_s2       <= c_s1;
         state_q    <= state_d;
         skew_cnt_q <= skew_cnt_d;
         to_cnt_q   <= to_cnt_d;
         lead_q     <= lead_d;
         trail_q    <= trail_d;
         hs_q       <= hs_d;
         early_q    <= early_d;
         tout_q     <= tout_d;
         if (cfg_load) begin
            cnt_q     <= hs.cfg_count;
            skew_q    <= hs.cfg_skew;
            b_first_q <= hs.cfg_b_first;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      skew_cnt_d = skew_cnt_q;
      to_cnt_d   = to_cnt_q;
      lead_d     = lead_q;
      trail_d    = trail_q;
      hs_d       = hs_q;
      early_d    = early_q;
      tout_d     = tout_q;
      cfg_load   = 1'b0;

      // stop outranks start and every state transition
      if (hs.stop) begin
         state_d = S_IDLE;
         lead_d  = 1'b0;
         trail_d = 1'b0;
      end else if (accept) begin
         state_d  = S_R_LEAD;
         cfg_load = 1'b1;
         hs_d     = '0;
         early_d  = 1'b0;
         tout_d   = 1'b0;
         lead_d   = 1'b0;
         trail_d  = 1'b0;
      end else begin
         case (state_q)
            S_R_LEAD: begin
               lead_d     = 1'b1;
               skew_cnt_d = skew_q;
               if (skew_q == '0) begin
                  trail_d  = 1'b1;
                  to_cnt_d = TO_LOAD;
                  state_d  = S_R_WAIT;
               end else begin
                  state_d = S_R_SKEW;
               end
            end
            S_R_SKEW: begin
               skew_cnt_d = skew_cnt_q - SKEW_W'(1);
               if (c_s2) begin
                  early_d = 1'b1;
                  lead_d  = 1'b0;
                  trail_d = 1'b0;
                  state_d = S_ERROR;
               end else if (skew_cnt_q == SKEW_W'(1)) begin
                  trail_d  = 1'b1;
                  to_cnt_d = TO_LOAD;
                  state_d  = S_R_WAIT;
               end
            end
            S_R_WAIT: begin
               if (c_s2) begin
                  state_d = S_F_LEAD;
               end else if (to_cnt_q == '0) begin
                  tout_d  = 1'b1;
                  lead_d  = 1'b0;
                  trail_d = 1'b0;
                  state_d = S_ERROR;
               end else begin
                  to_cnt_d = to_cnt_q - TO_W'(1);
               end
            end
            S_F_LEAD: begin
               lead_d     = 1'b0;
               skew_cnt_d = skew_q;
               if (skew_q == '0) begin
                  trail_d  = 1'b0;
                  to_cnt_d = TO_LOAD;
                  state_d  = S_F_WAIT;
               end else begin
                  state_d = S_F_SKEW;
               end
            end
            S_F_SKEW: begin
               skew_cnt_d = skew_cnt_q - SKEW_W'(1);
               if (!c_s2) begin
                  early_d = 1'b1;
                  lead_d  = 1'b0;
                  trail_d = 1'b0;
                  state_d = S_ERROR;
               end else if (skew_cnt_q == SKEW_W'(1)) begin
                  trail_d  = 1'b0;
                  to_cnt_d = TO_LOAD;
                  state_d  = S_F_WAIT;
               end
            end
            S_F_WAIT: begin
               if (!c_s2) begin
                  hs_d    = hs_inc;
                  state_d = (hs_inc == cnt_q) ? S_DONE : S_R_LEAD;
               end else if (to_cnt_q == '0) begin
                  tout_d  = 1'b1;
                  lead_d  = 1'b0;
                  trail_d = 1'b0;
                  state_d = S_ERROR;
               end else begin
                  to_cnt_d = to_cnt_q - TO_W'(1);
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
         endcase
      end
   end

   assign hs.a_out       = b_first_q ? trail_q : lead_q;
   assign hs.b_out       = b_first_q ? lead_q : trail_q;
   assign hs.busy        = !idle_like;
   assign hs.done        = (state_q == S_DONE);
   assign hs.err_early   = early_q;
   assign hs.err_timeout = tout_q;
   assign hs.hs_count    = hs_q;
endmodule
